// File: rtl/regalu_seq.sv
// Command sequencer for an external register-file/ALU (regalu): accepts LOAD/ALU/READ
// commands, drives one regalu access cycle, then holds a response until consumed.
module regalu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_kind,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_a,
    input  logic [2:0]  cmd_b,
    input  logic [2:0]  cmd_dst,
    input  logic [15:0] cmd_imm,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_cout,
    output logic        rsp_err,
    output logic        sel,
    output logic        wr,
    output logic [1:0]  op,
    output logic [2:0]  rd_addr_a,
    output logic [2:0]  rd_addr_b,
    output logic [2:0]  wr_addr,
    output logic [15:0] d_in,
    input  logic [15:0] d_out_a,
    input  logic [15:0] d_out_b,
    input  logic        cout,
    output logic [7:0]  cmd_count
);
    localparam logic [1:0] K_LOAD = 2'b00;
    localparam logic [1:0] K_ALU  = 2'b01;
    localparam logic [1:0] K_READ = 2'b10;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic [1:0]  kind_q, op_q;
    logic [2:0]  a_q, b_q, dst_q;
    logic [15:0] imm_q, rsp_data_q;
    logic        is_exec, is_resp;
    logic        unused;

    // Operand B only feeds the ALU inside regalu; the sequencer never looks at it.
    assign unused = ^d_out_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            kind_q     <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            rsp_data_q <= '0;
            rsp_cout   <= 1'b0;
            rsp_err    <= 1'b0;
            cmd_count  <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    kind_q <= cmd_kind;
                    op_q   <= cmd_op;
                    a_q    <= cmd_a;
                    b_q    <= cmd_b;
                    dst_q  <= cmd_dst;
                    imm_q  <= cmd_imm;
                    state  <= EXEC;
                end
                EXEC: begin
                    case (kind_q)
                        K_LOAD:  rsp_data_q <= imm_q;
                        K_READ:  rsp_data_q <= d_out_a;
                        default: rsp_data_q <= '0;
                    endcase
                    rsp_cout <= (kind_q == K_ALU) ? cout : 1'b0;
                    rsp_err  <= (kind_q == 2'b11);
                    state    <= RESP;
                end
                RESP: if (rsp_ready) begin
                    cmd_count <= cmd_count + 8'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign is_exec   = (state == EXEC);
    assign is_resp   = (state == RESP);
    assign cmd_ready = (state == IDLE) && !reset;
    assign rsp_valid = is_resp && !reset;
    assign wr        = is_exec && !reset && ((kind_q == K_LOAD) || (kind_q == K_ALU));
    assign sel       = is_exec && (kind_q == K_ALU);
    assign d_in      = (is_exec && kind_q == K_LOAD) ? imm_q : 16'h0000;
    assign op        = is_exec ? op_q : 2'b00;
    assign rd_addr_b = is_exec ? b_q : 3'd0;
    assign wr_addr   = is_exec ? dst_q : 3'd0;

    // The ALU result is written at the EXEC->RESP edge, so it is read back from dst in RESP.
    assign rd_addr_a = is_exec ? a_q : ((is_resp && kind_q == K_ALU) ? dst_q : 3'd0);
    assign rsp_data  = (is_resp && kind_q == K_ALU) ? d_out_a : rsp_data_q;
endmodule

// File: tb/tb_regalu_seq.sv
// Directed bench for regalu_seq with a small behavioural regalu (8x16 regfile + ALU).
module tb_regalu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_kind, cmd_op;
    logic [2:0]  cmd_a, cmd_b, cmd_dst;
    logic [15:0] cmd_imm;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_cout, rsp_err;
    logic        sel, wr;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a, rd_addr_b, wr_addr;
    logic [15:0] d_in, d_out_a, d_out_b;
    logic        cout;
    logic [7:0]  cmd_count;

    int checks = 0;
    int errors = 0;
    int wr_pulses = 0;

    logic [15:0] regs [8];
    logic [15:0] alu_res;

    logic        ex_wr, ex_sel;
    logic [15:0] ex_din;
    logic [2:0]  ex_wa, ex_ra, ex_rb;
    logic [1:0]  ex_op;
    logic        r_valid, r_cout, r_err;
    logic [15:0] r_data;

    always #5 clk = ~clk;

    regalu_seq dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cout(rsp_cout), .rsp_err(rsp_err),
        .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .wr_addr(wr_addr), .d_in(d_in), .d_out_a(d_out_a), .d_out_b(d_out_b),
        .cout(cout), .cmd_count(cmd_count)
    );

    // Behavioural regalu: combinational reads and ALU, write on the clock edge while wr=1.
    assign d_out_a = regs[rd_addr_a];
    assign d_out_b = regs[rd_addr_b];
    always_comb begin
        {cout, alu_res} = 17'h0;
        case (op)
            2'b00: {cout, alu_res} = {1'b0, d_out_a} + {1'b0, d_out_b};
            2'b01: {cout, alu_res} = {1'b0, d_out_a} - {1'b0, d_out_b};
            2'b10: alu_res = d_out_a & d_out_b;
            default: alu_res = d_out_a | d_out_b;
        endcase
    end
    always @(posedge clk) begin
        if (wr) begin
            regs[wr_addr] <= sel ? alu_res : d_in;
            wr_pulses <= wr_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full command: accept, snapshot EXEC outputs, snapshot response, handshake.
    task automatic run_cmd(input logic [1:0] k, input logic [1:0] o, input logic [2:0] a,
                           input logic [2:0] b, input logic [2:0] d, input logic [15:0] im);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = k; cmd_op = o; cmd_a = a; cmd_b = b; cmd_dst = d; cmd_imm = im;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        ex_wr = wr; ex_sel = sel; ex_din = d_in; ex_wa = wr_addr;
        ex_ra = rd_addr_a; ex_rb = rd_addr_b; ex_op = op;
        @(negedge clk);
        r_valid = rsp_valid; r_data = rsp_data; r_cout = rsp_cout; r_err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    initial begin
        int p0;
        logic [7:0] c0;
        for (int i = 0; i < 8; i++) regs[i] = 16'h0;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_kind = 2'b00; cmd_op = 2'b00; cmd_a = 3'd0; cmd_b = 3'd0; cmd_dst = 3'd0; cmd_imm = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_count", 32'(cmd_count), 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_outs", {sel, wr, d_in, wr_addr, rd_addr_a}, 32'd0);

        // LOAD r3=CDEF then READ r3
        p0 = wr_pulses;
        run_cmd(2'b00, 2'b00, 3'd0, 3'd0, 3'd3, 16'hCDEF);
        check("load_exec_wr", {ex_wr, ex_sel, ex_wa}, {28'd0, 1'b1, 1'b0, 3'd3});
        check("load_exec_din", 32'(ex_din), 32'hCDEF);
        check("load_pulses", 32'(wr_pulses - p0), 32'd1);
        check("load_rsp", {r_valid, r_err, r_data}, {14'd0, 1'b1, 1'b0, 16'hCDEF});
        check("load_r3", 32'(regs[3]), 32'hCDEF);
        p0 = wr_pulses;
        run_cmd(2'b10, 2'b00, 3'd3, 3'd0, 3'd0, 16'h0);
        check("read_rsp", {r_valid, r_err, r_data}, {14'd0, 1'b1, 1'b0, 16'hCDEF});
        check("read_nowr", 32'(wr_pulses - p0) + 32'(ex_wr), 32'd0);

        // LOAD r7=3210, ALU add r3+r7 -> r2 = FFFF, no carry
        run_cmd(2'b00, 2'b00, 3'd0, 3'd0, 3'd7, 16'h3210);
        p0 = wr_pulses;
        run_cmd(2'b01, 2'b00, 3'd3, 3'd7, 3'd2, 16'h0);
        check("alu_exec_addr", {ex_ra, ex_rb, ex_wa, ex_op}, {21'd0, 3'd3, 3'd7, 3'd2, 2'b00});
        check("alu_exec_ctl", {ex_wr, ex_sel}, 32'd3);
        check("alu_pulses", 32'(wr_pulses - p0), 32'd1);
        check("alu_rsp", {r_valid, r_cout, r_data}, {15'd0, 1'b1, 1'b0, 16'hFFFF});
        // r3+r3 -> r4 = 19BDE: carry out
        run_cmd(2'b01, 2'b00, 3'd3, 3'd3, 3'd4, 16'h0);
        check("alu_carry_rsp", {r_cout, r_data}, {15'd0, 1'b1, 16'h9BDE});
        check("alu_r4", 32'(regs[4]), 32'h9BDE);

        // Illegal command
        c0 = cmd_count; p0 = wr_pulses;
        run_cmd(2'b11, 2'b00, 3'd3, 3'd3, 3'd1, 16'h5555);
        check("ill_rsp", {r_valid, r_err, r_data}, {14'd0, 1'b1, 1'b1, 16'h0});
        check("ill_nowr", 32'(wr_pulses - p0) + 32'(ex_wr), 32'd0);
        @(negedge clk);
        check("ill_count", 32'(cmd_count), 32'(c0 + 8'd1));
        check("count_after6", 32'(cmd_count), 32'd6);

        // Response back-pressure with a competing command offered
        p0 = wr_pulses;
        cmd_valid = 1'b1; cmd_kind = 2'b10; cmd_a = 3'd7;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_dst = 3'd1; cmd_imm = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            check("stall_state", {rsp_valid, cmd_ready, rsp_data}, {14'd0, 1'b1, 1'b0, 16'h3210});
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        check("stall_nowr", 32'(wr_pulses - p0), 32'd0);
        check("stall_r1", 32'(regs[1]), 32'd0);
        check("stall_count", 32'(cmd_count), 32'd7);

        // Reset during EXEC of LOAD r5
        cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_dst = 3'd5; cmd_imm = 16'hABCD;
        @(posedge clk); #1 cmd_valid = 1'b0; reset = 1'b1;
        p0 = wr_pulses;
        @(negedge clk);
        check("rstexec_wr", 32'(wr), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstexec_idle", {rsp_valid, cmd_ready}, 32'd1);
        end
        check("rstexec_r5", 32'(regs[5]), 32'd0);
        check("rstexec_pulses", 32'(wr_pulses - p0), 32'd0);
        check("rstexec_count", 32'(cmd_count), 32'd0);

        // 256 READs wrap the counter
        for (int i = 0; i < 256; i++) begin
            run_cmd(2'b10, 2'b00, 3'(i), 3'd0, 3'd0, 16'h0);
            if (i == 254) begin
                @(negedge clk);
                check("count_255", 32'(cmd_count), 32'd255);
            end
        end
        @(negedge clk);
        check("count_wrap", 32'(cmd_count), 32'd0);
        check("wrap_r7_read", 32'(r_data), 32'h3210);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/regalu_seq.md
REGALU_SEQ -- requirements
Module: regalu_seq

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-005 SHALL have port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high at a clk edge.
REQ-006 SHALL have port cmd_kind, input, 2 bits: 00 LOAD, 01 ALU, 10 READ, 11 illegal.
REQ-007 SHALL have ports cmd_op (2 bits), cmd_a (3 bits), cmd_b (3 bits), cmd_dst (3 bits) and cmd_imm (16 bits), all inputs: ALU op, read addresses A/B, destination, immediate.
REQ-008 SHALL have port rsp_valid, output, 1 bit: response available.
REQ-009 SHALL have port rsp_ready, input, 1 bit: response consumed when rsp_valid and rsp_ready are both high at a clk edge.
REQ-010 SHALL have ports rsp_data (output, 16 bits), rsp_cout (output, 1 bit) and rsp_err (output, 1 bit): result, carry, illegal-command flag.
REQ-011 SHALL have ports sel, wr, op[1:0], rd_addr_a[2:0], rd_addr_b[2:0], wr_addr[2:0] and d_in[15:0], all outputs, driving regalu.
  - sel=1 writes the ALU result; sel=0 writes d_in.
REQ-012 SHALL have ports d_out_a[15:0], d_out_b[15:0] and cout, all inputs, from regalu.
  - Reads are combinational; the write occurs at the clk edge while wr=1.
REQ-013 SHALL have port cmd_count, output, 8 bits: count of completed responses.

Function
REQ-014 SHALL implement the states IDLE, EXEC and RESP.
REQ-015 SHALL assert cmd_ready only in IDLE.
REQ-016 SHALL latch all cmd_* fields on acceptance, then move IDLE->EXEC.
REQ-017 SHALL hold rd_addr_a, rd_addr_b, op and wr_addr from the latched fields during EXEC, and at 0 in the other states.
REQ-018 SHALL drive EXEC as follows, then move EXEC->RESP:
  - LOAD: wr=1, sel=0, d_in=imm.
  - ALU: wr=1, sel=1.
  - READ: wr=0.
  - illegal: wr=0.
REQ-019 SHALL assert wr for exactly one cycle per LOAD or ALU command, and never in any other state.
REQ-020 SHALL capture rsp_data at the EXEC->RESP edge as follows:
  - LOAD: imm.
  - ALU: the ALU result via d_out_a of wr_addr, re-read in RESP; rsp_data becomes valid in RESP through combinational read of cmd_dst.
  - READ: d_out_a.
  - illegal: 0.
REQ-021 SHALL capture rsp_cout from cout at the EXEC->RESP edge for ALU commands only, and set it to 0 otherwise.
REQ-022 SHALL set rsp_err=1 only for illegal commands, with no regalu write.
REQ-023 SHALL hold rsp_valid=1 in RESP, with all rsp_* outputs stable until the handshake.
REQ-024 SHALL move RESP->IDLE on the handshake and increment cmd_count, wrapping 255->0.
REQ-025 SHALL meet the following latency: accept at edge N, EXEC in cycle N..N+1, rsp_valid high from edge N+1; best-case throughput is one command per 3 cycles.
REQ-026 SHALL, if rsp_ready is already high when RESP is entered, spend exactly one cycle in RESP.
REQ-027 SHALL ignore cmd_valid outside IDLE; commands are neither lost nor duplicated.
REQ-028 SHALL drive d_in=0 and sel=0 outside EXEC.

Reset
REQ-029 SHALL, at a clk edge with reset=1, clear the following and return to IDLE:
  - state, latched fields, rsp_data, rsp_cout, rsp_err, cmd_count.
REQ-030 SHALL force cmd_ready, rsp_valid and wr to 0 combinationally while reset=1, so no regalu write occurs at a reset edge even in EXEC.
REQ-031 SHALL discard an in-flight command on reset mid-operation, producing no response.
REQ-032 SHALL allow acceptance in the first cycle after reset deasserts.

Verification
REQ-033 SHALL cover: LOAD dst=3 imm=16'hCDEF, then READ a=3 -> one wr pulse with wr_addr=3, sel=0, d_in=CDEF; READ gives rsp_data=CDEF, rsp_err=0.
REQ-034 SHALL cover: LOAD r7=16'h3210, then ALU op=00 a=3 b=7 dst=2 -> EXEC shows rd_addr_a=3, rd_addr_b=7, wr_addr=2, sel=1, wr=1 for one cycle; rsp_cout equals regalu cout.
REQ-035 SHALL cover: cmd_kind=11 -> rsp_err=1, rsp_data=0, wr never high, cmd_count increments.
REQ-036 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid stays high, rsp_data stable, cmd_ready=0, a second cmd_valid is not accepted.
REQ-037 SHALL cover: reset asserted during the EXEC of a LOAD to r5 -> wr=0 at that edge, r5 unchanged, IDLE next, no rsp_valid.
REQ-038 SHALL cover: 256 READ commands -> cmd_count returns to 0.
